// File: rtl/sw_digit_entry_if.sv
// Bundle of the switch/button inputs and the digit-buffer outputs of sw_digit_entry.
// No handshake: inputs are raw asynchronous levels; outputs are registered levels valid every cycle.
interface sw_digit_entry_if #(
  parameter int DIGITS = 8
);
  logic [3:0]          SW;
  logic                BTN_PUSH;
  logic                BTN_CLR;
  logic [4*DIGITS-1:0] DIGITS_OUT;
  logic [DIGITS-1:0]   VALID;
  logic [3:0]          COUNT;
  logic                FULL;
  logic                PUSH_PULSE;

  modport master (
    output SW, BTN_PUSH, BTN_CLR,
    input  DIGITS_OUT, VALID, COUNT, FULL, PUSH_PULSE
  );

  modport slave (
    input  SW, BTN_PUSH, BTN_CLR,
    output DIGITS_OUT, VALID, COUNT, FULL, PUSH_PULSE
  );
endinterface

// File: rtl/sw_digit_entry.sv
// Synchronises and debounces the push/clear buttons and switch nibble, and shifts
// the switch value into a DIGITS-deep hex buffer on each debounced press.
module sw_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DIGITS          = 8
) (
  input  logic           CLK,
  input  logic           RST,
  sw_digit_entry_if.slave bus
);
  localparam int          W       = 4 * DIGITS;
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  CNT_MAX = 4'(DIGITS);

  // Button index 0 = push, 1 = clear.
  logic [3:0]        sw_s1, sw_s;
  logic [1:0]        btn_s1, btn_s;
  logic [1:0]        deb, deb_prev;
  logic [23:0]       db_cnt [2];
  logic [W-1:0]      digits_r;
  logic [DIGITS-1:0] valid_r;
  logic [3:0]        count_r;
  logic              pulse_r;
  logic              push_ev, clr_ev;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_s1  <= '0;
      sw_s   <= '0;
      btn_s1 <= '0;
      btn_s  <= '0;
    end else begin
      sw_s1  <= bus.SW;
      sw_s   <= sw_s1;
      btn_s1 <= {bus.BTN_CLR, bus.BTN_PUSH};
      btn_s  <= btn_s1;
    end
  end

  // A level must disagree with the debounced state for DEBOUNCE_CYCLES
  // consecutive cycles before it is accepted; any agreement restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb       <= '0;
      deb_prev  <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      deb_prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= btn_s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 24'd1;
        end
      end
    end
  end

  assign push_ev = deb[0] & ~deb_prev[0];
  assign clr_ev  = deb[1] & ~deb_prev[1];

  // Clear has priority over push; a push when full drops the oldest digit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      digits_r <= '0;
      valid_r  <= '0;
      count_r  <= '0;
      pulse_r  <= 1'b0;
    end else begin
      pulse_r <= push_ev & ~clr_ev;
      if (clr_ev) begin
        digits_r <= '0;
        valid_r  <= '0;
        count_r  <= '0;
      end else if (push_ev) begin
        digits_r <= (digits_r << 4) | W'(sw_s);
        valid_r  <= (valid_r << 1) | DIGITS'(1);
        if (count_r != CNT_MAX) count_r <= count_r + 4'd1;
      end
    end
  end

  assign bus.DIGITS_OUT = digits_r;
  assign bus.VALID      = valid_r;
  assign bus.COUNT      = count_r;
  assign bus.FULL       = (count_r == CNT_MAX);
  assign bus.PUSH_PULSE = pulse_r;
endmodule

// File: tb/tb_sw_digit_entry.sv
// Bench for sw_digit_entry: scenario tasks with inline checks plus a scoreboard
// that pops the expected buffer contents on every PUSH_PULSE.
module tb_sw_digit_entry;
  localparam int DB     = 4;
  localparam int DIGITS = 8;
  localparam int W      = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sw_digit_entry_if #(.DIGITS(DIGITS)) bus ();

  sw_digit_entry #(.DEBOUNCE_CYCLES(DB), .DIGITS(DIGITS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_pass    = 0;
  int n_total   = 0;
  int pulse_cnt = 0;

  // ---------------- model / scoreboard ----------------
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      model_digits;
  logic [DIGITS-1:0] model_valid;
  int                model_count;

  task automatic model_reset();
    model_digits = '0;
    model_valid  = '0;
    model_count  = 0;
  endtask

  task automatic model_push(input logic [3:0] v);
    model_digits = (model_digits << 4) | W'(v);
    model_valid  = (model_valid << 1) | DIGITS'(1);
    if (model_count < DIGITS) model_count++;
    exp_q.push_back(model_digits);
  endtask

  always @(negedge CLK) begin
    if (!RST && bus.PUSH_PULSE) begin
      logic [W-1:0] e;
      pulse_cnt++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_pulse: unexpected PUSH_PULSE, DIGITS_OUT=%h, no entry expected", bus.DIGITS_OUT);
      end else begin
        e = exp_q.pop_front();
        if (bus.DIGITS_OUT !== e) $display("FAIL sb_digits: got %h want %h", bus.DIGITS_OUT, e);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input logic [3:0] v, input logic p, input logic c, input int hold, input int rel);
    bus.SW       = v;
    bus.BTN_PUSH = p;
    bus.BTN_CLR  = c;
    repeat (hold) @(negedge CLK);
    bus.BTN_PUSH = 1'b0;
    bus.BTN_CLR  = 1'b0;
    repeat (rel) @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1;
    bus.SW = 4'h0; bus.BTN_PUSH = 1'b0; bus.BTN_CLR = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_total++; if (bus.DIGITS_OUT !== '0) $display("FAIL reset_digits: got %h want 0", bus.DIGITS_OUT); else n_pass++;
    n_total++; if (bus.VALID !== '0) $display("FAIL reset_valid: got %h want 0", bus.VALID); else n_pass++;
    n_total++; if (bus.COUNT !== 4'd0) $display("FAIL reset_count: got %0d want 0", bus.COUNT); else n_pass++;
    n_total++; if (bus.FULL !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.FULL); else n_pass++;
    n_total++; if (bus.PUSH_PULSE !== 1'b0) $display("FAIL reset_pulse: got %b want 0", bus.PUSH_PULSE); else n_pass++;
  endtask

  task automatic test_basic_push();
    int p0 = pulse_cnt;
    bus.SW = 4'hA; bus.BTN_PUSH = 1'b1;
    model_push(4'hA);
    repeat (6) @(negedge CLK);
    n_total++; if (bus.COUNT !== 4'd0) $display("FAIL basic_early: count %0d at edge 6, want 0", bus.COUNT); else n_pass++;
    n_total++; if (bus.PUSH_PULSE !== 1'b0) $display("FAIL basic_early_pulse: got %b want 0", bus.PUSH_PULSE); else n_pass++;
    @(negedge CLK);
    n_total++; if (bus.DIGITS_OUT !== 32'h0000000A) $display("FAIL basic_digits: got %h want 0000000a", bus.DIGITS_OUT); else n_pass++;
    n_total++; if (bus.VALID !== 8'h01) $display("FAIL basic_valid: got %h want 01", bus.VALID); else n_pass++;
    n_total++; if (bus.COUNT !== 4'd1) $display("FAIL basic_count: got %0d want 1", bus.COUNT); else n_pass++;
    n_total++; if (bus.PUSH_PULSE !== 1'b1) $display("FAIL basic_pulse: got %b want 1", bus.PUSH_PULSE); else n_pass++;
    @(negedge CLK);
    n_total++; if (bus.PUSH_PULSE !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", bus.PUSH_PULSE); else n_pass++;
    repeat (12) @(negedge CLK);
    bus.BTN_PUSH = 1'b0;
    repeat (10) @(negedge CLK);
    n_total++; if (pulse_cnt !== p0 + 1) $display("FAIL basic_one_event: pulses %0d want %0d", pulse_cnt - p0, 1); else n_pass++;
  endtask

  task automatic test_bounce();
    int p0 = pulse_cnt;
    bus.SW = 4'h5;
    for (int i = 0; i < 15; i++) begin
      bus.BTN_PUSH = (i % 2 == 0);
      repeat (2) @(negedge CLK);
    end
    bus.BTN_PUSH = 1'b0;
    repeat (12) @(negedge CLK);
    n_total++; if (bus.DIGITS_OUT !== model_digits) $display("FAIL bounce_digits: got %h want %h", bus.DIGITS_OUT, model_digits); else n_pass++;
    n_total++; if (bus.VALID !== model_valid) $display("FAIL bounce_valid: got %h want %h", bus.VALID, model_valid); else n_pass++;
    n_total++; if (bus.COUNT !== 4'(model_count)) $display("FAIL bounce_count: got %0d want %0d", bus.COUNT, model_count); else n_pass++;
    n_total++; if (pulse_cnt !== p0) $display("FAIL bounce_pulse: pulses %0d want 0", pulse_cnt - p0); else n_pass++;
  endtask

  task automatic test_fill_wrap();
    press(4'h0, 1'b0, 1'b1, 10, 10);
    model_reset();
    n_total++; if (bus.COUNT !== 4'd0) $display("FAIL fill_preclear: got %0d want 0", bus.COUNT); else n_pass++;
    for (int v = 1; v <= 9; v++) begin
      model_push(4'(v));
      press(4'(v), 1'b1, 1'b0, 10, 10);
      if (v == 8) begin
        n_total++; if (bus.DIGITS_OUT !== 32'h12345678) $display("FAIL fill_digits: got %h want 12345678", bus.DIGITS_OUT); else n_pass++;
        n_total++; if (bus.FULL !== 1'b1) $display("FAIL fill_full: got %b want 1", bus.FULL); else n_pass++;
        n_total++; if (bus.COUNT !== 4'd8) $display("FAIL fill_count: got %0d want 8", bus.COUNT); else n_pass++;
        n_total++; if (bus.VALID !== 8'hFF) $display("FAIL fill_valid: got %h want ff", bus.VALID); else n_pass++;
      end
    end
    n_total++; if (bus.DIGITS_OUT !== 32'h23456789) $display("FAIL wrap_digits: got %h want 23456789", bus.DIGITS_OUT); else n_pass++;
    n_total++; if (bus.COUNT !== 4'd8) $display("FAIL wrap_count: got %0d want 8", bus.COUNT); else n_pass++;
    n_total++; if (bus.FULL !== 1'b1) $display("FAIL wrap_full: got %b want 1", bus.FULL); else n_pass++;
  endtask

  task automatic test_clear();
    bus.BTN_CLR = 1'b1;
    model_reset();
    repeat (6) @(negedge CLK);
    n_total++; if (bus.COUNT !== 4'd8) $display("FAIL clear_early: count %0d at edge 6, want 8", bus.COUNT); else n_pass++;
    @(negedge CLK);
    n_total++; if (bus.DIGITS_OUT !== '0) $display("FAIL clear_digits: got %h want 0", bus.DIGITS_OUT); else n_pass++;
    n_total++; if (bus.VALID !== '0) $display("FAIL clear_valid: got %h want 0", bus.VALID); else n_pass++;
    n_total++; if (bus.COUNT !== 4'd0) $display("FAIL clear_count: got %0d want 0", bus.COUNT); else n_pass++;
    n_total++; if (bus.FULL !== 1'b0) $display("FAIL clear_full: got %b want 0", bus.FULL); else n_pass++;
    n_total++; if (bus.PUSH_PULSE !== 1'b0) $display("FAIL clear_pulse: got %b want 0", bus.PUSH_PULSE); else n_pass++;
    repeat (8) @(negedge CLK);
    bus.BTN_CLR = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_simultaneous();
    int p0;
    logic [3:0] v;
    for (int k = 0; k < 3; k++) begin
      v = 4'($urandom_range(0, 15));
      model_push(v);
      press(v, 1'b1, 1'b0, 10, 10);
    end
    n_total++; if (bus.COUNT !== 4'd3) $display("FAIL simul_pre_count: got %0d want 3", bus.COUNT); else n_pass++;
    n_total++; if (bus.DIGITS_OUT !== model_digits) $display("FAIL simul_pre_digits: got %h want %h", bus.DIGITS_OUT, model_digits); else n_pass++;
    p0 = pulse_cnt;
    bus.BTN_PUSH = 1'b1; bus.BTN_CLR = 1'b1;
    model_reset();
    repeat (7) @(negedge CLK);
    n_total++; if (bus.COUNT !== 4'd0) $display("FAIL simul_count: got %0d want 0", bus.COUNT); else n_pass++;
    n_total++; if (bus.VALID !== '0) $display("FAIL simul_valid: got %h want 0", bus.VALID); else n_pass++;
    n_total++; if (bus.DIGITS_OUT !== '0) $display("FAIL simul_digits: got %h want 0", bus.DIGITS_OUT); else n_pass++;
    repeat (8) @(negedge CLK);
    bus.BTN_PUSH = 1'b0; bus.BTN_CLR = 1'b0;
    repeat (10) @(negedge CLK);
    n_total++; if (pulse_cnt !== p0) $display("FAIL simul_pulse: pulses %0d want 0", pulse_cnt - p0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p0;
    logic [3:0] v;
    for (int k = 0; k < 5; k++) begin
      v = 4'($urandom_range(0, 15));
      model_push(v);
      press(v, 1'b1, 1'b0, 10, 10);
    end
    n_total++; if (bus.COUNT !== 4'd5) $display("FAIL mid_pre_count: got %0d want 5", bus.COUNT); else n_pass++;
    v = 4'($urandom_range(0, 15));
    bus.SW = v; bus.BTN_PUSH = 1'b1;
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    n_total++; if (bus.DIGITS_OUT !== '0) $display("FAIL mid_rst_digits: got %h want 0", bus.DIGITS_OUT); else n_pass++;
    n_total++; if (bus.VALID !== '0) $display("FAIL mid_rst_valid: got %h want 0", bus.VALID); else n_pass++;
    n_total++; if (bus.COUNT !== 4'd0) $display("FAIL mid_rst_count: got %0d want 0", bus.COUNT); else n_pass++;
    n_total++; if (bus.FULL !== 1'b0) $display("FAIL mid_rst_full: got %b want 0", bus.FULL); else n_pass++;
    n_total++; if (bus.PUSH_PULSE !== 1'b0) $display("FAIL mid_rst_pulse: got %b want 0", bus.PUSH_PULSE); else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    model_push(v);
    p0 = pulse_cnt;
    repeat (6) @(negedge CLK);
    n_total++; if (bus.COUNT !== 4'd0) $display("FAIL mid_early: count %0d at edge 6, want 0", bus.COUNT); else n_pass++;
    @(negedge CLK);
    n_total++; if (bus.COUNT !== 4'd1) $display("FAIL mid_count: got %0d want 1", bus.COUNT); else n_pass++;
    n_total++; if (bus.DIGITS_OUT !== W'(v)) $display("FAIL mid_digits: got %h want %h", bus.DIGITS_OUT, W'(v)); else n_pass++;
    n_total++; if (bus.PUSH_PULSE !== 1'b1) $display("FAIL mid_pulse: got %b want 1", bus.PUSH_PULSE); else n_pass++;
    repeat (15) @(negedge CLK);
    n_total++; if (pulse_cnt !== p0 + 1) $display("FAIL mid_one_event: pulses %0d want 1", pulse_cnt - p0); else n_pass++;
    bus.BTN_PUSH = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus.SW = 4'h0; bus.BTN_PUSH = 1'b0; bus.BTN_CLR = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic_push();
    test_bounce();
    test_fill_wrap();
    test_clear();
    test_simultaneous();
    test_reset_mid();
    n_total++; if (exp_q.size() != 0) $display("FAIL sb_drain: %0d expected pushes never seen", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
